// File: rtl/sync_fifo_thr.sv
// sync_fifo_thr: single-clock FIFO with occupancy count, almost-full/almost-empty thresholds, FWFT option, flush and sticky error flags
// Ports: clk/rst (sync, active-high); flush empties the FIFO; winc/wdata write; rinc/rdata read;
//        wfull/rempty/almost_full/almost_empty are decoded from count; overflow/underflow are sticky until rst.
module sync_fifo_thr #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH-2,
  parameter int AE_LEVEL = 2,
  parameter int FWFT     = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     winc,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     rinc,
  output logic [WIDTH-1:0]         rdata,
  output logic                     wfull,
  output logic                     rempty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] L_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] L_AF   = (AW+1)'(AF_LEVEL);
  localparam logic [AW:0] L_AE   = (AW+1)'(AE_LEVEL);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr, r_rptr;
  logic [AW:0]      r_count;
  logic             r_ovf, r_udf;
  logic             w_wen, w_ren;
  assign wfull        = r_count == L_FULL;
  assign rempty       = r_count == '0;
  assign almost_full  = r_count >= L_AF;
  assign almost_empty = r_count <= L_AE;
  assign count        = r_count;
  assign overflow     = r_ovf;
  assign underflow    = r_udf;
  assign w_wen        = winc & ~wfull & ~flush;
  assign w_ren        = rinc & ~rempty & ~flush;
  always_ff @(posedge clk)
    if (w_wen) r_mem[r_wptr] <= wdata;
  always_ff @(posedge clk)
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_udf   <= 1'b0;
    end else begin
      if (winc & wfull & ~flush) r_ovf <= 1'b1;
      if (rinc & rempty & ~flush) r_udf <= 1'b1;
      if (flush) begin
        r_wptr  <= '0;
        r_rptr  <= '0;
        r_count <= '0;
      end else begin
        if (w_wen) r_wptr <= r_wptr + 1'b1;
        if (w_ren) r_rptr <= r_rptr + 1'b1;
        r_count <= r_count + {{AW{1'b0}}, w_wen} - {{AW{1'b0}}, w_ren};
      end
    end
  generate
    if (FWFT != 0) begin : g_fwft
      assign rdata = r_mem[r_rptr];
    end else begin : g_std
      logic [WIDTH-1:0] r_rdata;
      always_ff @(posedge clk)
        if (rst) r_rdata <= '0;
        else if (w_ren) r_rdata <= r_mem[r_rptr];
      assign rdata = r_rdata;
    end
  endgenerate
endmodule

// File: tb/tb_sync_fifo_thr.sv
// tb_sync_fifo_thr: randomized and directed checks of both read modes against a queue-based model
module tb_sync_fifo_thr;
  localparam int W = 8, D = 16, AF = 14, AE = 2;
  logic clk = 0, rst = 0, flush = 0, winc = 0, rinc = 0;
  logic [W-1:0] wdata = 0;
  logic [W-1:0] rdata_a, rdata_b;
  logic wfull_a, rempty_a, af_a, ae_a, ovf_a, udf_a;
  logic wfull_b, rempty_b, af_b, ae_b, ovf_b, udf_b;
  logic [4:0] count_a, count_b;
  int n_tests = 0, n_fail = 0;
  logic [W-1:0] q[$];
  logic m_ovf = 0, m_udf = 0;
  logic [W-1:0] m_rd = 0;
  always #5 clk = ~clk;
  sync_fifo_thr #(.WIDTH(W), .DEPTH(D), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(0)) u_std (
    .clk(clk), .rst(rst), .flush(flush), .winc(winc), .wdata(wdata), .rinc(rinc),
    .rdata(rdata_a), .wfull(wfull_a), .rempty(rempty_a), .almost_full(af_a),
    .almost_empty(ae_a), .count(count_a), .overflow(ovf_a), .underflow(udf_a));
  sync_fifo_thr #(.WIDTH(W), .DEPTH(D), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(1)) u_fwft (
    .clk(clk), .rst(rst), .flush(flush), .winc(winc), .wdata(wdata), .rinc(rinc),
    .rdata(rdata_b), .wfull(wfull_b), .rempty(rempty_b), .almost_full(af_b),
    .almost_empty(ae_b), .count(count_b), .overflow(ovf_b), .underflow(udf_b));
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask
  task automatic compare();
    int n = q.size();
    check("count_std", 32'(count_a), 32'(n));
    check("count_fwft", 32'(count_b), 32'(n));
    check("rempty", 32'({rempty_a, rempty_b}), {30'd0, {2{n == 0}}});
    check("wfull", 32'({wfull_a, wfull_b}), {30'd0, {2{n == D}}});
    check("almost_full", 32'({af_a, af_b}), {30'd0, {2{n >= AF}}});
    check("almost_empty", 32'({ae_a, ae_b}), {30'd0, {2{n <= AE}}});
    check("overflow", 32'({ovf_a, ovf_b}), {30'd0, {2{m_ovf}}});
    check("underflow", 32'({udf_a, udf_b}), {30'd0, {2{m_udf}}});
    check("rdata_std", 32'(rdata_a), 32'(m_rd));
    if (n != 0) check("rdata_fwft", 32'(rdata_b), 32'(q[0]));
  endtask
  task automatic step(input logic w, input logic [W-1:0] wd, input logic r, input logic fl, input logic rs);
    logic full, empty;
    winc = w; wdata = wd; rinc = r; flush = fl; rst = rs;
    @(posedge clk);
    full = q.size() == D;
    empty = q.size() == 0;
    if (rs) begin
      q.delete(); m_ovf = 0; m_udf = 0; m_rd = 0;
    end else begin
      if (w && full && !fl) m_ovf = 1;
      if (r && empty && !fl) m_udf = 1;
      if (fl) q.delete();
      else begin
        if (r && !empty) m_rd = q.pop_front();
        if (w && !full) q.push_back(wd);
      end
    end
    #1;
    compare();
  endtask
  initial begin
    logic [W-1:0] d;
    step(0, 0, 0, 0, 1);
    check("reset_count", 32'(count_a), 0);
    check("reset_rdata", 32'(rdata_a), 0);
    for (int i = 1; i <= 16; i++) step(1, W'(i), 0, 0, 0);
    check("fill_full", 32'(wfull_a), 1);
    step(1, 8'h77, 0, 0, 0);
    check("fill_ovf", 32'(ovf_a), 1);
    check("fill_cnt", 32'(count_a), 16);
    for (int i = 1; i <= 16; i++) begin
      step(0, 0, 1, 0, 0);
      check("drain_data", 32'(rdata_a), 32'(i));
    end
    step(0, 0, 1, 0, 0);
    check("drain_udf", 32'(udf_a), 1);
    check("drain_hold", 32'(rdata_a), 32'h10);
    step(1, 8'hA5, 0, 0, 0);
    check("fwft_head", 32'(rdata_b), 32'hA5);
    step(0, 0, 1, 0, 0);
    check("fwft_empty", 32'(rempty_b), 1);
    step(0, 0, 0, 0, 1);
    d = 8'h30;
    for (int i = 0; i < 5; i++) begin step(1, d, 0, 0, 0); d++; end
    for (int i = 0; i < 40; i++) begin step(1, d, 1, 0, 0); d++; end
    check("simul_cnt", 32'(count_a), 5);
    while (q.size() < D) begin step(1, d, 0, 0, 0); d++; end
    step(1, d, 1, 0, 0);
    check("full_both_cnt", 32'(count_a), 15);
    while (q.size() > 0) step(0, 0, 1, 0, 0);
    step(1, 8'h5A, 1, 0, 0);
    check("empty_both_cnt", 32'(count_a), 1);
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 9; i++) step(1, W'($urandom_range(0, 255)), 0, 0, 0);
    step(1, 8'hEE, 0, 1, 0);
    check("flush_empty", 32'(rempty_a), 1);
    step(1, 8'h3C, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    check("flush_new", 32'(rdata_a), 32'h3C);
    for (int i = 0; i < 17; i++) step(1, W'(i), 0, 0, 0);
    for (int i = 0; i < 9; i++) step(0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 1);
    check("rst_mid_ovf", 32'(ovf_a), 0);
    check("rst_mid_rdata", 32'(rdata_a), 0);
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 99) < 60, W'($urandom_range(0, 255)), $urandom_range(0, 99) < 50,
           $urandom_range(0, 99) < 2, $urandom_range(0, 199) < 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
